vga_timing_generator: RTL and testbench

- Parametrised VGA raster timing source: derives a pixel strobe from the system clock, walks the full horizontal/vertical raster, and emits sync, blanking, logical coordinates, framebuffer address and frame/line event pulses.
- Sits between the system clock domain and the framebuffer read port / video DAC pins.
- Generalises the fixed 640x480 sync generator:
  - all porch and sync widths, sync polarities and clock divide are parametrised;
  - adds pixel-scaling (logical grid coarser than raster);
  - adds incremental address generation without a multiplier, plus frame/line/vblank outputs for simulation-update scheduling.

---
 rtl/vga_timing_generator.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_generator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: parametrised VGA raster timing source.
// Divides clk_i into a pixel strobe, walks the full h/v raster and emits
// registered sync, blanking, scaled logical coordinates, a multiplier-free
// framebuffer address and frame/line event pulses.
// Optional macro VGA_TIMING_TEST_PATTERN_EN adds an RGB444 colour-bar output.
module vga_timing_generator #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 4,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int SCALE_SHIFT = 0,
  parameter int FRAME_CNT_W = 8,
  localparam int LW = H_ACTIVE >> SCALE_SHIFT,
  localparam int LH = V_ACTIVE >> SCALE_SHIFT,
  localparam int XW = ($clog2(LW) > 1) ? $clog2(LW) : 1,
  localparam int YW = ($clog2(LH) > 1) ? $clog2(LH) : 1,
  localparam int AW = ($clog2(LW * LH) > 1) ? $clog2(LW * LH) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic                   pix_stb_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   video_en_o,
  output logic                   vblank_o,
  output logic [XW-1:0]          x_o,
  output logic [YW-1:0]          y_o,
  output logic [AW-1:0]          addr_o,
  output logic                   line_start_o,
  output logic                   frame_start_o,
  output logic [FRAME_CNT_W-1:0] frame_count_o
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [11:0]            pattern_o
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = ($clog2(H_TOTAL) > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = ($clog2(V_TOTAL) > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW      = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SMASK   = (1 << SCALE_SHIFT) - 1;

  logic [DW-1:0] div, div_next;
  logic          stb_next;
  logic [HW-1:0] h, h_next;
  logic [VW-1:0] v, v_next;
  logic          h_wrap, v_wrap;
  logic [AW-1:0] row_base, row_base_next;
  logic [31:0]   hn, vn;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic          video_en_next, vblank_next, hsync_act, vsync_act;

  // Divider next count; the strobe is registered so it is high exactly while
  // the divider sits at CLK_DIV-1 (continuously high when CLK_DIV is 1).
  always_comb begin
    div_next = (div == DW'(CLK_DIV - 1)) ? '0 : div + DW'(1);
    stb_next = (div_next == DW'(CLK_DIV - 1));
  end

  // Clock divider and pixel strobe register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div       <= '0;
      pix_stb_o <= 1'b0;
    end else begin
      div       <= div_next;
      pix_stb_o <= stb_next;
    end
  end

  // Next raster position and everything decoded from it, so outputs land on
  // the same edge as the counters.
  always_comb begin
    h_wrap        = (h == HW'(H_TOTAL - 1));
    v_wrap        = (v == VW'(V_TOTAL - 1));
    h_next        = h_wrap ? '0 : h + HW'(1);
    v_next        = v;
    row_base_next = row_base;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v + VW'(1);
      if (v_wrap)
        row_base_next = '0;
      else if (((v & VW'(SMASK)) == VW'(SMASK)) && (v < VW'(V_ACTIVE - 1)))
        row_base_next = row_base + AW'(LW);
    end
    hn            = 32'(h_next);
    vn            = 32'(v_next);
    hsync_act     = (hn >= H_ACTIVE + H_FRONT) && (hn < H_ACTIVE + H_FRONT + H_SYNC);
    vsync_act     = (vn >= V_ACTIVE + V_FRONT) && (vn < V_ACTIVE + V_FRONT + V_SYNC);
    video_en_next = (hn < H_ACTIVE) && (vn < V_ACTIVE);
    vblank_next   = (vn >= V_ACTIVE);
    x_next        = (hn < H_ACTIVE) ? XW'(hn >> SCALE_SHIFT) : '0;
    y_next        = (vn < V_ACTIVE) ? YW'(vn >> SCALE_SHIFT) : '0;
  end

  // Raster counters and registered outputs; event pulses self-clear next cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      h             <= HW'(H_TOTAL - 1);
      v             <= VW'(V_TOTAL - 1);
      row_base      <= '0;
      hsync_o       <= ~HSYNC_POL;
      vsync_o       <= ~VSYNC_POL;
      video_en_o    <= 1'b0;
      vblank_o      <= 1'b1;
      x_o           <= '0;
      y_o           <= '0;
      addr_o        <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      frame_count_o <= '0;
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
      if (pix_stb_o) begin
        h             <= h_next;
        v             <= v_next;
        row_base      <= row_base_next;
        hsync_o       <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
        vsync_o       <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
        video_en_o    <= video_en_next;
        vblank_o      <= vblank_next;
        x_o           <= x_next;
        y_o           <= y_next;
        addr_o        <= vblank_next ? '0 : row_base_next + AW'(x_next);
        line_start_o  <= (h_next == '0) && !vblank_next;
        frame_start_o <= (h_next == '0) && (v_next == '0);
        if ((h_next == '0) && (v_next == '0))
          frame_count_o <= frame_count_o + FRAME_CNT_W'(1);
      end
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  logic [BW-1:0] bar_px, bar_px_next;
  logic [2:0]    bar_idx, bar_idx_next;

  // Bar index tracked incrementally along the line instead of dividing h.
  always_comb begin
    bar_px_next  = bar_px + BW'(1);
    bar_idx_next = bar_idx;
    if (h_next == '0) begin
      bar_px_next  = '0;
      bar_idx_next = '0;
    end else if (bar_px == BW'(BAR_W - 1)) begin
      bar_px_next  = '0;
      bar_idx_next = bar_idx + 3'd1;
    end
  end

  // Colour-bar register, blanked outside the active region.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bar_px    <= '0;
      bar_idx   <= '0;
      pattern_o <= '0;
    end else if (pix_stb_o) begin
      bar_px    <= bar_px_next;
      bar_idx   <= bar_idx_next;
      pattern_o <= video_en_next ? {{4{bar_idx_next[2]}}, {4{bar_idx_next[1]}}, {4{bar_idx_next[0]}}} : 12'h000;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: three small-raster instances (plain, scaled,
// undivided with inverted polarity) checked every cycle against a model that
// derives the raster position from the edge count since reset release.
// Random mid-cycle reset pulses exercise the asynchronous reset.
module tb_vga_timing_generator;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;

  typedef struct packed {
    logic [31:0] stb, hs, vs, ven, vbl, x, y, addr, ls, fs, fc, pat;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  longint k_cnt = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance A: CLK_DIV=4, no scaling, active-low syncs.
  logic a_stb, a_hs, a_vs, a_ven, a_vbl, a_ls, a_fs;
  logic [3:0] a_x; logic [2:0] a_y; logic [6:0] a_addr; logic [7:0] a_fc;
  // Instance B: CLK_DIV=3, SCALE_SHIFT=1.
  logic b_stb, b_hs, b_vs, b_ven, b_vbl, b_ls, b_fs;
  logic [2:0] b_x; logic [1:0] b_y; logic [4:0] b_addr; logic [7:0] b_fc;
  // Instance C: CLK_DIV=1, active-high syncs, 4-bit frame counter.
  logic c_stb, c_hs, c_vs, c_ven, c_vbl, c_ls, c_fs;
  logic [3:0] c_x; logic [2:0] c_y; logic [6:0] c_addr; logic [3:0] c_fc;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0] a_pat, b_pat, c_pat;
`endif

  vga_timing_generator #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(4),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_SHIFT(0), .FRAME_CNT_W(8)) dut_a (
    .clk_i(clk), .reset_i(rst), .pix_stb_o(a_stb), .hsync_o(a_hs), .vsync_o(a_vs),
    .video_en_o(a_ven), .vblank_o(a_vbl), .x_o(a_x), .y_o(a_y), .addr_o(a_addr),
    .line_start_o(a_ls), .frame_start_o(a_fs), .frame_count_o(a_fc)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .pattern_o(a_pat)
`endif
  );

  vga_timing_generator #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE_SHIFT(1), .FRAME_CNT_W(8)) dut_b (
    .clk_i(clk), .reset_i(rst), .pix_stb_o(b_stb), .hsync_o(b_hs), .vsync_o(b_vs),
    .video_en_o(b_ven), .vblank_o(b_vbl), .x_o(b_x), .y_o(b_y), .addr_o(b_addr),
    .line_start_o(b_ls), .frame_start_o(b_fs), .frame_count_o(b_fc)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .pattern_o(b_pat)
`endif
  );

  vga_timing_generator #(.H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .SCALE_SHIFT(0), .FRAME_CNT_W(4)) dut_c (
    .clk_i(clk), .reset_i(rst), .pix_stb_o(c_stb), .hsync_o(c_hs), .vsync_o(c_vs),
    .video_en_o(c_ven), .vblank_o(c_vbl), .x_o(c_x), .y_o(c_y), .addr_o(c_addr),
    .line_start_o(c_ls), .frame_start_o(c_fs), .frame_count_o(c_fc)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .pattern_o(c_pat)
`endif
  );

  outs_t oa, ob, oc;

  // Gather each instance's outputs into one comparable record.
  always_comb begin
    oa = '{32'(a_stb), 32'(a_hs), 32'(a_vs), 32'(a_ven), 32'(a_vbl), 32'(a_x),
           32'(a_y), 32'(a_addr), 32'(a_ls), 32'(a_fs), 32'(a_fc), 32'd0};
    ob = '{32'(b_stb), 32'(b_hs), 32'(b_vs), 32'(b_ven), 32'(b_vbl), 32'(b_x),
           32'(b_y), 32'(b_addr), 32'(b_ls), 32'(b_fs), 32'(b_fc), 32'd0};
    oc = '{32'(c_stb), 32'(c_hs), 32'(c_vs), 32'(c_ven), 32'(c_vbl), 32'(c_x),
           32'(c_y), 32'(c_addr), 32'(c_ls), 32'(c_fs), 32'(c_fc), 32'd0};
`ifdef VGA_TIMING_TEST_PATTERN_EN
    oa.pat = 32'(a_pat);
    ob.pat = 32'(b_pat);
    oc.pat = 32'(c_pat);
`endif
  end

  // Edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) k_cnt <= 0;
    else     k_cnt <= k_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] b2w(input bit b);
    return b ? 32'd1 : 32'd0;
  endfunction

  // Pixel advances completed after k edges (first strobe is registered, so
  // an undivided clock advances from the second edge on).
  function automatic longint adv(input longint k, input int d);
    if (k <= 0) return 0;
    return (d == 1) ? k - 1 : k / d;
  endfunction

  function automatic outs_t model(input longint k, input int d, input bit hp,
                                  input bit vp, input int s, input int fw);
    outs_t e;
    longint p, idx;
    int ht, vt, h, v, bar, lw;
    ht = HA + HF + HS + HB;
    vt = VA + VF + VS + VB;
    lw = HA >> s;
    p  = adv(k, d);
    e  = '0;
    e.stb = b2w(adv(k + 1, d) != p);
    if (p == 0) begin
      e.hs  = b2w(!hp);
      e.vs  = b2w(!vp);
      e.vbl = 32'd1;
      return e;
    end
    idx = p - 1;
    h   = int'(idx % ht);
    v   = int'((idx / ht) % vt);
    e.hs   = b2w(((h >= HA + HF) && (h < HA + HF + HS)) ? hp : !hp);
    e.vs   = b2w(((v >= VA + VF) && (v < VA + VF + VS)) ? vp : !vp);
    e.ven  = b2w(h < HA && v < VA);
    e.vbl  = b2w(v >= VA);
    e.x    = (h < HA) ? 32'(h >> s) : 32'd0;
    e.y    = (v < VA) ? 32'(v >> s) : 32'd0;
    e.addr = (v < VA) ? e.y * 32'(lw) + e.x : 32'd0;
    e.ls   = b2w(adv(k - 1, d) != p && h == 0 && v < VA);
    e.fs   = b2w(adv(k - 1, d) != p && h == 0 && v == 0);
    e.fc   = 32'(((idx / (ht * vt)) + 1) % (longint'(1) << fw));
    bar    = h / (HA / 8);
    if (e.ven[0])
      e.pat = 32'(((bar >> 2) & 1) * 12'hF00 + ((bar >> 1) & 1) * 12'h0F0 + (bar & 1) * 12'h00F);
    return e;
  endfunction

  task automatic cmp(input string nm, input outs_t g, input outs_t e);
    check_eq({nm, ".pix_stb"}, g.stb, e.stb);
    check_eq({nm, ".hsync"}, g.hs, e.hs);
    check_eq({nm, ".vsync"}, g.vs, e.vs);
    check_eq({nm, ".video_en"}, g.ven, e.ven);
    check_eq({nm, ".vblank"}, g.vbl, e.vbl);
    check_eq({nm, ".x"}, g.x, e.x);
    check_eq({nm, ".y"}, g.y, e.y);
    check_eq({nm, ".addr"}, g.addr, e.addr);
    check_eq({nm, ".line_start"}, g.ls, e.ls);
    check_eq({nm, ".frame_start"}, g.fs, e.fs);
    check_eq({nm, ".frame_count"}, g.fc, e.fc);
`ifdef VGA_TIMING_TEST_PATTERN_EN
    check_eq({nm, ".pattern"}, g.pat, e.pat);
`endif
  endtask

  task automatic cmp_all(input longint k);
    cmp("A", oa, model(k, 4, 1'b0, 1'b0, 0, 8));
    cmp("B", ob, model(k, 3, 1'b0, 1'b0, 1, 8));
    cmp("C", oc, model(k, 1, 1'b1, 1'b1, 0, 4));
  endtask

  // Every cycle, away from the active edge, compare all instances.
  always @(negedge clk) begin
    cmp_all(rst ? 0 : k_cnt);
    if (a_fs) $display("frame A count=%0d t=%0t", a_fc, $time);
    if (b_fs) $display("frame B count=%0d t=%0t", b_fc, $time);
    if (c_fs) $display("frame C count=%0d t=%0t", c_fc, $time);
  end

  initial begin
    int hold, run, off;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6000) @(negedge clk);
    for (int ep = 0; ep < 6; ep++) begin
      run = int'($urandom_range(2000, 50));
      repeat (run) @(negedge clk);
      @(posedge clk);
      off = int'($urandom_range(3, 1));
      #(off);
      rst = 1'b1;
      #1;
      cmp_all(0);
      hold = int'($urandom_range(4, 1));
      $display("reset pulse %0d after %0d cycles, offset %0d, hold %0d", ep, run, off, hold);
      repeat (hold) @(negedge clk);
      rst = 1'b0;
    end
    repeat (1500) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
